// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-addressed main memory between dcache (rw) and icache (ro).
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default gives dcache priority.
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_address_i,
    input  logic [DATA_W-1:0] d_writedata_i,
    output logic [DATA_W-1:0] d_readdata_o,
    output logic              d_busywait_o,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_address_i,
    output logic [DATA_W-1:0] i_readdata_o,
    output logic              i_busywait_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [DATA_W-1:0] mem_writedata_o,
    input  logic [DATA_W-1:0] mem_readdata_i,
    input  logic              mem_busywait_i
);
    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, started_q, started_d;
    logic d_req, i_req, owner_req, gnt, complete, pick;
    assign d_req     = d_read_i | d_write_i;
    assign i_req     = i_read_i;
    assign owner_req = owner_q ? i_req : d_req;
    assign gnt       = state_q == GRANT;
    assign complete  = gnt && started_q && !mem_busywait_i;
`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;
    assign pick   = (d_req && i_req) ? !last_q : i_req;
    assign last_d = (state_q == IDLE && (d_req || i_req)) ? pick : last_q;
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) last_q <= 1'b0;
        else last_q <= last_d;
`else
    assign pick = !d_req;
`endif
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            started_q <= started_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        started_d = started_q;
        case (state_q)
            IDLE: if (d_req || i_req) begin
                state_d   = GRANT;
                owner_d   = pick;
                started_d = 1'b0;
            end
            GRANT: begin
                started_d = started_q | mem_busywait_i;
                if (complete || !owner_req) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end
    // a simultaneous dcache read+write is treated as a write
    assign mem_read_o      = gnt && (owner_q ? i_read_i : (d_read_i && !d_write_i));
    assign mem_write_o     = gnt && !owner_q && d_write_i;
    assign mem_address_o   = !gnt ? '0 : (owner_q ? i_address_i : d_address_i);
    assign mem_writedata_o = (gnt && !owner_q) ? d_writedata_i : '0;
    assign d_busywait_o    = d_req && !(complete && !owner_q);
    assign i_busywait_o    = i_req && !(complete && owner_q);
    assign d_readdata_o    = mem_readdata_i;
    assign i_readdata_o    = mem_readdata_i;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a latency memory model
// and a reference memory image.
module tb_mem_arbiter;
    logic        clk_i = 0, reset_i = 0;
    logic        d_read_i = 0, d_write_i = 0, i_read_i = 0;
    logic [5:0]  d_address_i = 0, i_address_i = 0;
    logic [31:0] d_writedata_i = 0;
    logic [31:0] d_readdata_o, i_readdata_o, mem_writedata_o;
    logic        d_busywait_o, i_busywait_o, mem_read_o, mem_write_o;
    logic [5:0]  mem_address_o;
    logic [31:0] mem_rdata = 0;
    logic        mem_busy = 0, jd = 0;
    int          cnt = 0, lat = 5, vectors = 0, miscompares = 0;
    bit          noresp = 0;
    logic [31:0] mem [64];
    logic [63:0] wr_v = '0;
    logic [31:0] ref_mem [64];

    mem_arbiter dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .d_read_i(d_read_i), .d_write_i(d_write_i), .d_address_i(d_address_i),
        .d_writedata_i(d_writedata_i), .d_readdata_o(d_readdata_o), .d_busywait_o(d_busywait_o),
        .i_read_i(i_read_i), .i_address_i(i_address_i), .i_readdata_o(i_readdata_o),
        .i_busywait_o(i_busywait_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_address_o(mem_address_o), .mem_writedata_o(mem_writedata_o),
        .mem_readdata_i(mem_rdata), .mem_busywait_i(mem_busy)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input logic [5:0] a);
        return (a == 6'h15) ? 32'hCAFE_F00D : 32'h5A00_0000 + {26'd0, a} * 32'h0001_0101;
    endfunction

    // memory: busy for lat cycles after seeing a strobe, then one idle-handshake cycle
    always @(posedge clk_i) begin
        if (!(mem_read_o || mem_write_o)) begin
            mem_busy <= 0; jd <= 0; cnt <= 0;
        end else if (jd || noresp) begin
        end else if (!mem_busy) begin
            mem_busy <= 1; cnt <= lat - 1;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end else begin
            mem_busy  <= 0;
            jd        <= 1;
            mem_rdata <= wr_v[mem_address_o] ? mem[mem_address_o] : init_word(mem_address_o);
            if (mem_write_o) begin
                mem[mem_address_o]  <= mem_writedata_o;
                wr_v[mem_address_o] <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic wait_done(input bit port, output int cyc);
        cyc = 0;
        do begin tick(); cyc++; end
        while ((port ? i_busywait_o : d_busywait_o) && cyc < 60);
        if (port ? i_busywait_o : d_busywait_o) cyc = -1;
    endtask

    task automatic test_reset();
        reset_i = 1; #3;
        vectors++;
        if ({mem_read_o, mem_write_o, mem_address_o, mem_writedata_o} !== '0) begin
            miscompares++; $display("FAIL reset_mem_outs: got %b/%b/%h/%h exp 0", mem_read_o, mem_write_o, mem_address_o, mem_writedata_o);
        end
        vectors++;
        if ({d_busywait_o, i_busywait_o} !== 2'b00) begin
            miscompares++; $display("FAIL reset_busy_idle: got %b exp 00", {d_busywait_o, i_busywait_o});
        end
        d_read_i = 1; #1;
        vectors++;
        if ({d_busywait_o, i_busywait_o} !== 2'b10) begin
            miscompares++; $display("FAIL reset_busy_follow: got %b exp 10", {d_busywait_o, i_busywait_o});
        end
        d_read_i = 0;
        tick(); reset_i = 0;
    endtask

    task automatic test_lone_read();
        int cyc;
        lat = 5; d_read_i = 1; d_address_i = 6'h15; #1;
        vectors++;
        if (d_busywait_o !== 1 || mem_read_o !== 0) begin
            miscompares++; $display("FAIL lone_pre_grant: busy %b rd %b exp 1 0", d_busywait_o, mem_read_o);
        end
        tick();
        vectors++;
        if ({mem_read_o, mem_write_o, mem_address_o} !== {2'b10, 6'h15}) begin
            miscompares++; $display("FAIL lone_grant: got %b%b %h exp 10 15", mem_read_o, mem_write_o, mem_address_o);
        end
        wait_done(0, cyc);
        vectors++;
        if (cyc !== lat + 1) begin
            miscompares++; $display("FAIL lone_latency: got %0d exp %0d", cyc, lat + 1);
        end
        vectors++;
        if (d_readdata_o !== 32'hCAFE_F00D || i_readdata_o !== 32'hCAFE_F00D) begin
            miscompares++; $display("FAIL lone_data: got %h/%h exp cafef00d", d_readdata_o, i_readdata_o);
        end
        tick();
        vectors++;
        if (mem_read_o !== 0 || d_busywait_o !== 1) begin
            miscompares++; $display("FAIL lone_done: rd %b busy %b exp 0 1", mem_read_o, d_busywait_o);
        end
        d_read_i = 0; tick();
        vectors++;
        if (d_busywait_o !== 0 || mem_read_o !== 0) begin
            miscompares++; $display("FAIL lone_idle: busy %b rd %b exp 0 0", d_busywait_o, mem_read_o);
        end
    endtask

    task automatic test_simultaneous();
        bit first, second;
        int cyc, n;
`ifdef MEM_ARB_RR_EN
        first = 1;
`else
        first = 0;
`endif
        second = !first;
        reset_i = 1; tick(); reset_i = 0;
        lat = 3;
        d_write_i = 1; d_address_i = 6'h03; d_writedata_i = 32'h1234_5678;
        i_read_i = 1; i_address_i = 6'h08;
        tick();
        vectors++;
        if (mem_write_o !== !first || mem_address_o !== (first ? 6'h08 : 6'h03)) begin
            miscompares++; $display("FAIL sim_first_grant: wr %b addr %h exp %b %h", mem_write_o, mem_address_o, !first, first ? 6'h08 : 6'h03);
        end
        n = 0;
        while (d_busywait_o && i_busywait_o && n < 60) begin tick(); n++; end
        vectors++;
        if ({i_busywait_o, d_busywait_o} !== (first ? 2'b01 : 2'b10)) begin
            miscompares++; $display("FAIL sim_first_done: i/d busy %b exp %b", {i_busywait_o, d_busywait_o}, first ? 2'b01 : 2'b10);
        end
        if (first) begin
            vectors++;
            if (i_readdata_o !== ref_mem[8]) begin
                miscompares++; $display("FAIL sim_i_data: got %h exp %h", i_readdata_o, ref_mem[8]);
            end
            i_read_i = 0;
        end else begin
            ref_mem[3] = 32'h1234_5678; d_write_i = 0;
        end
        tick();
        vectors++;
        if ((second ? i_busywait_o : d_busywait_o) !== 1 || {mem_read_o, mem_write_o} !== 2'b00) begin
            miscompares++; $display("FAIL sim_wait_done: busy %b strobes %b%b exp 1 00", second ? i_busywait_o : d_busywait_o, mem_read_o, mem_write_o);
        end
        tick();
        vectors++;
        if ((second ? i_busywait_o : d_busywait_o) !== 1 || {mem_read_o, mem_write_o} !== 2'b00) begin
            miscompares++; $display("FAIL sim_wait_idle: busy %b strobes %b%b exp 1 00", second ? i_busywait_o : d_busywait_o, mem_read_o, mem_write_o);
        end
        tick();
        vectors++;
        if (mem_address_o !== (second ? 6'h08 : 6'h03)) begin
            miscompares++; $display("FAIL sim_second_grant: addr %h exp %h", mem_address_o, second ? 6'h08 : 6'h03);
        end
        wait_done(second, cyc);
        vectors++;
        if (cyc < 0) begin
            miscompares++; $display("FAIL sim_second_timeout: got %0d exp >0", cyc);
        end
        if (second) begin
            vectors++;
            if (i_readdata_o !== ref_mem[8]) begin
                miscompares++; $display("FAIL sim_i_data2: got %h exp %h", i_readdata_o, ref_mem[8]);
            end
            i_read_i = 0;
        end else begin
            ref_mem[3] = 32'h1234_5678; d_write_i = 0;
        end
        tick(); tick();
        vectors++;
        if (mem[3] !== 32'h1234_5678) begin
            miscompares++; $display("FAIL sim_write_data: got %h exp 12345678", mem[3]);
        end
    endtask

    task automatic test_illegal();
        int cyc;
        logic [31:0] wd;
        wd = $urandom;
        d_read_i = 1; d_write_i = 1; d_address_i = 6'h05; d_writedata_i = wd;
        tick();
        vectors++;
        if ({mem_read_o, mem_write_o} !== 2'b01 || mem_writedata_o !== wd) begin
            miscompares++; $display("FAIL illegal_cmd: rd/wr %b%b data %h exp 01 %h", mem_read_o, mem_write_o, mem_writedata_o, wd);
        end
        wait_done(0, cyc);
        vectors++;
        if (cyc < 0) begin
            miscompares++; $display("FAIL illegal_timeout: got %0d exp >0", cyc);
        end
        ref_mem[5] = wd;
        d_read_i = 0; d_write_i = 0; tick(); tick();
        vectors++;
        if (mem[5] !== wd) begin
            miscompares++; $display("FAIL illegal_stored: got %h exp %h", mem[5], wd);
        end
    endtask

    task automatic test_abort();
        int cyc;
        noresp = 1;
        i_read_i = 1; i_address_i = 6'h2A;
        tick();
        vectors++;
        if (mem_read_o !== 1 || mem_address_o !== 6'h2A) begin
            miscompares++; $display("FAIL abort_grant: rd %b addr %h exp 1 2a", mem_read_o, mem_address_o);
        end
        d_read_i = 1; d_address_i = 6'h11;
        tick();
        vectors++;
        if ({i_busywait_o, d_busywait_o, mem_read_o} !== 3'b111) begin
            miscompares++; $display("FAIL abort_stalled: i/d/rd %b exp 111", {i_busywait_o, d_busywait_o, mem_read_o});
        end
        i_read_i = 0;
        tick();
        vectors++;
        if (mem_read_o !== 0 || mem_address_o !== 0 || d_busywait_o !== 1) begin
            miscompares++; $display("FAIL abort_done: rd %b addr %h busy %b exp 0 00 1", mem_read_o, mem_address_o, d_busywait_o);
        end
        tick();
        vectors++;
        if (mem_read_o !== 0 || d_busywait_o !== 1) begin
            miscompares++; $display("FAIL abort_idle: rd %b busy %b exp 0 1", mem_read_o, d_busywait_o);
        end
        noresp = 0;
        tick();
        vectors++;
        if (mem_read_o !== 1 || mem_address_o !== 6'h11) begin
            miscompares++; $display("FAIL abort_pending_grant: rd %b addr %h exp 1 11", mem_read_o, mem_address_o);
        end
        wait_done(0, cyc);
        vectors++;
        if (cyc < 0 || d_readdata_o !== ref_mem[6'h11]) begin
            miscompares++; $display("FAIL abort_pending_data: cyc %0d data %h exp %h", cyc, d_readdata_o, ref_mem[6'h11]);
        end
        d_read_i = 0; tick(); tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        d_read_i = 1; d_address_i = 6'h07;
        tick(); tick(); tick();
        vectors++;
        if (mem_read_o !== 1) begin
            miscompares++; $display("FAIL rstmid_pre: rd %b exp 1", mem_read_o);
        end
        #2 reset_i = 1; #1;
        vectors++;
        if ({mem_read_o, mem_write_o, mem_address_o} !== '0 || d_busywait_o !== 1) begin
            miscompares++; $display("FAIL rstmid_async: rd/wr %b%b addr %h busy %b exp 00 00 1", mem_read_o, mem_write_o, mem_address_o, d_busywait_o);
        end
        tick(); reset_i = 0;
        tick();
        vectors++;
        if (mem_read_o !== 1 || mem_address_o !== 6'h07) begin
            miscompares++; $display("FAIL rstmid_regrant: rd %b addr %h exp 1 07", mem_read_o, mem_address_o);
        end
        wait_done(0, cyc);
        vectors++;
        if (cyc < 0 || d_readdata_o !== ref_mem[7]) begin
            miscompares++; $display("FAIL rstmid_data: cyc %0d data %h exp %h", cyc, d_readdata_o, ref_mem[7]);
        end
        d_read_i = 0; tick(); tick();
    endtask

    task automatic test_random();
        int d_gap = 0, i_gap = 0, d_cnt = 0, i_cnt = 0;
        bit d_act = 0, i_act = 0, d_wr = 0;
        for (int c = 0; c < 1500; c++) begin
            lat = $urandom_range(1, 4);
            vectors++;
            if ((!d_act && d_busywait_o) || (!i_act && i_busywait_o) || (d_act && i_act && !d_busywait_o && !i_busywait_o)) begin
                miscompares++; $display("FAIL rand_busy c%0d: d %b/%b i %b/%b", c, d_act, d_busywait_o, i_act, i_busywait_o);
            end
            if (d_act && !d_busywait_o) begin
                vectors++;
                if (mem_address_o !== d_address_i || mem_write_o !== d_wr || (!d_wr && d_readdata_o !== ref_mem[d_address_i])) begin
                    miscompares++; $display("FAIL rand_d c%0d: addr %h wr %b data %h exp %h %b %h", c, mem_address_o, mem_write_o, d_readdata_o, d_address_i, d_wr, ref_mem[d_address_i]);
                end
                if (d_wr) ref_mem[d_address_i] = d_writedata_i;
                d_act = 0; d_read_i = 0; d_write_i = 0; d_gap = $urandom_range(0, 3); d_cnt++;
            end else if (!d_act) begin
                if (d_gap == 0) begin
                    d_act = 1; d_wr = $urandom_range(0, 2) == 0;
                    d_read_i = !d_wr; d_write_i = d_wr;
                    d_address_i = 6'($urandom_range(0, 7)); d_writedata_i = $urandom;
                end else d_gap--;
            end
            if (i_act && !i_busywait_o) begin
                vectors++;
                if (mem_address_o !== i_address_i || i_readdata_o !== ref_mem[i_address_i]) begin
                    miscompares++; $display("FAIL rand_i c%0d: addr %h data %h exp %h %h", c, mem_address_o, i_readdata_o, i_address_i, ref_mem[i_address_i]);
                end
                i_act = 0; i_read_i = 0; i_gap = $urandom_range(0, 3); i_cnt++;
            end else if (!i_act) begin
                if (i_gap == 0) begin
                    i_act = 1; i_read_i = 1; i_address_i = 6'($urandom_range(0, 7));
                end else i_gap--;
            end
            tick();
        end
        d_read_i = 0; d_write_i = 0; i_read_i = 0;
        tick(); tick(); tick();
        vectors++;
        if (d_cnt < 20 || i_cnt < 20) begin
            miscompares++; $display("FAIL rand_progress: d %0d i %0d exp >=20 each", d_cnt, i_cnt);
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) ref_mem[k] = init_word(6'(k));
        test_reset();
        test_lone_read();
        test_simultaneous();
        test_illegal();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-requester arbiter that shares the single block-addressed main data memory between the data cache (port `d_`, read/write) and the instruction cache (port `i_`, read-only).
- Sits between both cache FSMs and main memory, and sequences one whole memory transaction at a time.
- Forwards the owning requester's command, address and write data, and returns `mem_readdata` to both ports.
- Holds the non-owner's busywait high until it is granted.

## Interface
- `ADDR_W`, default 6: memory block address width.
- `DATA_W`, default 32: memory block width.

Ports:
- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high.
- `d_read` in 1: dcache block read request.
- `d_write` in 1: dcache block write-back request.
- `d_address` in ADDR_W: dcache block address.
- `d_writedata` in DATA_W: dcache write-back data.
- `d_readdata` out DATA_W: equals `mem_readdata`.
- `d_busywait` out 1: dcache stall.
- `i_read` in 1: icache block read request.
- `i_address` in ADDR_W: icache block address.
- `i_readdata` out DATA_W: equals `mem_readdata`.
- `i_busywait` out 1: icache stall.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_address` out ADDR_W: memory block address.
- `mem_writedata` out DATA_W: memory write data.
- `mem_readdata` in DATA_W: memory read data.
- `mem_busywait` in 1: memory busy.

## Operation
Request definitions:
- `d_req = d_read | d_write`; `i_req = i_read`.
- `d_read && d_write` together is illegal. It is treated as a write: `mem_read` forced 0.

States and transitions (all on posedge):
- IDLE:
  - No request -> stay in IDLE.
  - Else grant one port (see Configuration), latch `owner`, clear `started` -> GRANT.
- GRANT:
  - Forward the owner's read/write/address/writedata to the `mem_*` outputs, combinationally from registered `owner`.
  - Set `started` at the first posedge with `mem_busywait`=1.
  - At the posedge with `started && !mem_busywait` -> DONE.
  - If the owner drops its request before completion (abort) -> DONE.
- DONE:
  - All `mem_*` strobes 0, giving memory one clean idle cycle -> IDLE unconditionally. No arbitration happens in DONE.

Output values:
- In IDLE and DONE: `mem_read`=`mem_write`=0, `mem_address`=0, `mem_writedata`=0.
- Port busywait = `req && !(state==GRANT && owner==port && started && !mem_busywait)`.
  - Owner sees busywait 0 in exactly the completion cycle.
  - A non-requesting port always sees 0.
  - A waiting port stays 1 throughout.
- `d_readdata` and `i_readdata` are pure passthrough of `mem_readdata`. They are valid only in the owner's completion cycle.

## Timing
- Grant latency:
  - Request asserted before posedge T while in IDLE -> GRANT after T, `mem_*` valid within the same cycle.
  - Arriving in DONE -> granted at T+1.
- Transaction length: grant cycle + memory latency + 1 DONE cycle.
- Back-to-back requests from either port are separated by at least one DONE and one IDLE edge.
- Memory that never raises busywait: the transaction never completes. The requester stays stalled until it aborts.
- Reset, any time (including mid-transaction):
  - State -> IDLE, `started`=0, `owner`=d, round-robin pointer = "d last served" (i.e. i favoured next).
  - All `mem_*` outputs go to 0 immediately (asynchronously).
  - Busywaits follow their requests.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - On simultaneous `d_req` and `i_req` in IDLE, grant the port not served last.
  - Update `last` on each grant.
  - A lone request is always granted.
- Undefined: fixed priority. The dcache wins every simultaneous request; `last` is not implemented.

## Test plan
- Lone dcache read: `d_read`=1, `d_address`=6'h15, memory with 5-cycle latency returns 32'hCAFE_F00D -> `mem_read`=1 and `mem_address`=6'h15 after grant; `d_busywait` low for one cycle with `d_readdata`=32'hCAFE_F00D; DONE cycle shows `mem_read`=0.
- Simultaneous requests: `d_write` to 6'h03 with data 32'h1234_5678, plus `i_read` to 6'h08.
  - Fixed priority: dcache served first, `i_busywait` held 1 until the icache's own completion.
  - With `MEM_ARB_RR_EN` and a prior dcache grant: icache served first.
- Illegal command: `d_read`=`d_write`=1 -> `mem_write`=1, `mem_read`=0.
- Abort: owner drops `i_read` 2 cycles into GRANT -> DONE on the next edge, `mem_read`=0, then IDLE; a pending `d_req` is granted after IDLE.
- Reset mid-transaction: pulse `reset` while in GRANT -> `mem_read`/`mem_write` low without waiting for clk; after release, a re-asserted request is granted cleanly.
